multi_cycle_cpu: RTL and testbench
==================================

MULTI_CYCLE_CPU -- requirements
Module: multi_cycle_cpu

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning datapath and register width (min 16).
REQ-002 The block SHALL have parameter PC_W, default 8, meaning instruction-memory word-address width.
REQ-003 The block SHALL have parameter DADDR_W, default 10, meaning data-memory word-address width.
REQ-004 The block SHALL have parameter NREGS, default 32, meaning register count, power of two, at most 32.
REQ-005 The block SHALL have ports MAX10_CLK1_50 in 1 (sole clock, rising edge) and reset in 1 (synchronous, active-high).
REQ-006 The block SHALL have ports imem_req out 1, imem_addr out PC_W, imem_ready in 1 and imem_rdata in 32, forming the instruction fetch port.
REQ-007 The block SHALL have ports dmem_req out 1, dmem_we out 1, dmem_addr out DADDR_W, dmem_wdata out DATA_W, dmem_ready in 1 and dmem_rdata in DATA_W, forming the data port.
REQ-008 The block SHALL have ports pc out PC_W (current PC), state out 3 (FSM state encoding) and halted out 1 (core stopped).

Function
REQ-009 The FSM SHALL have states FETCH, DECODE, EXEC, MEM, WB and HALT; it never enters any other state.
REQ-010 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc; on a cycle with imem_ready=1 the block latches imem_rdata into IR, sets pc to pc+1 mod 2^PC_W and moves to DECODE; otherwise it stays in FETCH.
REQ-011 Decoding SHALL use opcode=IR[31:26], rs=IR[25:21], rt=IR[20:16], rd=IR[15:11], funct=IR[5:0] and imm=IR[15:0]; register indices use the low log2(NREGS) bits.
REQ-012 In DECODE the block SHALL latch A=R[rs] and B=R[rt]; imm is sign-extended to DATA_W.
REQ-013 Opcode 0 with funct 0x20/0x22/0x24/0x25/0x2A SHALL perform add/sub/and/or/slt (signed) with result R[rd]; the path is EXEC then WB.
REQ-014 Opcode 0x08 (addi) SHALL write A+sext(imm) to R[rt]; the path is EXEC then WB.
REQ-015 Opcode 0x23 (lw) SHALL take the path EXEC, MEM, WB, with dmem_addr=(A+sext(imm))[DADDR_W-1:0] and R[rt]=dmem_rdata, captured in the ready cycle.
REQ-016 Opcode 0x2B (sw) SHALL take the path EXEC, MEM, with dmem_we=1 and dmem_wdata=B, then return to FETCH.
REQ-017 Opcode 0x04 (beq) SHALL, in EXEC, set pc=pc+sext(imm) mod 2^PC_W if A==B, then go to FETCH.
REQ-018 Opcode 0x02 (j) SHALL, in EXEC, set pc=IR[PC_W-1:0], then go to FETCH.
REQ-019 Opcode 0x3F and any other unlisted opcode or funct SHALL go from DECODE to HALT; in HALT, halted=1, no requests are issued and the state is held until reset.
REQ-020 A held request (imem_req or dmem_req) SHALL keep its address, write data and dmem_we stable until the cycle in which ready=1; it deasserts the next cycle, and ready while the request is low is ignored.
REQ-021 The block SHALL allow ready=1 in the same cycle as the request rises, giving zero-wait; latencies are then R/addi 4 cycles, lw 5, sw 4, beq 3 and j 3, each extended by one cycle per wait state.
REQ-022 R[0] SHALL read as zero always; writes to R[0] are discarded.
REQ-023 Arithmetic SHALL be two's complement modulo 2^DATA_W with no overflow trap; PC arithmetic wraps modulo 2^PC_W (pc at max + 1 gives 0).
REQ-024 A register write SHALL occur only in WB, with exactly one write per instruction.

Reset
REQ-025 With reset=1 at a clock edge, pc SHALL become 0, the state FETCH, IR 0, imem_req/dmem_req/dmem_we 0 and halted 0, and all registers 0.
REQ-026 Reset SHALL take priority in any state, including during an outstanding wait-stated request; the aborted access causes no register write, and a memory write already presented with ready is not undone.
REQ-027 In the cycle after reset is released, imem_req SHALL be 1 with imem_addr=0.

Structure
REQ-028 Opcode/funct constants, the state encoding and the ALU-operation enum SHALL live in a shared package, cpu_pkg.
REQ-029 The register file SHALL be one sub-module, cpu_regfile: 2 async read ports, 1 sync write port, parameters DATA_W and NREGS, and synchronous reset.
REQ-030 The ALU, sign-extender and next-PC logic SHALL stay inside multi_cycle_cpu.

Verification
REQ-031 Scenario: zero-wait program "addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; halt" -> r3=2, halted=1 after 4+4+4+2 cycles.
REQ-032 Scenario: sw r1 to addr 7 then lw r4 from addr 7, with dmem_ready delayed 3 cycles each -> dmem_addr/wdata stable while waiting, r4=5, and each access lasts 4 MEM cycles.
REQ-033 Scenario: beq r1,r1,-1 at pc 3 -> pc returns to 3 repeatedly; with beq r1,r2 and r1≠r2 -> pc advances to 4.
REQ-034 Scenario: j 255 at PC_W=8, then an instruction at 255 executes -> pc wraps to 0 on that fetch.
REQ-035 Scenario: reset asserted in the 2nd wait cycle of lw -> next cycle state=FETCH, pc=0, no write to rt, and dmem_req=0.
REQ-036 Scenario: addi r0,r0,9 then add r5,r0,r0 -> r5=0; illegal opcode 0x11 -> HALT with halted=1 and no further imem_req.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU: FSM state encoding,
// ALU operation enum and the opcode / funct constants of the ISA.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

endpackage

// File: rtl/cpu_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port.
// Ports: clk, reset (sync, active-high, clears all), raddr1/2 -> rdata1/2,
// we/waddr/wdata write port. Register 0 always reads zero.
module cpu_regfile #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     raddr1,
    input  logic [AW-1:0]     raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-like core: FETCH/DECODE/EXEC/MEM/WB FSM with
// valid/ready style instruction and data ports.
// Ports: MAX10_CLK1_50 clock, reset (sync, active-high);
// imem_req/addr/ready/rdata fetch port; dmem_req/we/addr/wdata/ready/rdata
// data port; pc, state, halted status outputs.
module multi_cycle_cpu
    import cpu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int PC_W    = 8,
    parameter int DADDR_W = 10,
    parameter int NREGS   = 32
) (
    input  logic               MAX10_CLK1_50,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic [31:0]        imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic               dmem_ready,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic [PC_W-1:0]    pc,
    output logic [2:0]         state,
    output logic               halted
);

    localparam int RW = $clog2(NREGS);

    state_t            st;
    logic [31:0]       ir;
    logic [PC_W-1:0]   pc_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] mdr_q;

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [RW-1:0]     rs;
    logic [RW-1:0]     rt;
    logic [RW-1:0]     rd;
    logic [DATA_W-1:0] imm_ext;
    logic [PC_W-1:0]   br_off;

    assign opcode  = ir[31:26];
    assign funct   = ir[5:0];
    assign rs      = ir[21 +: RW];
    assign rt      = ir[16 +: RW];
    assign rd      = ir[11 +: RW];
    assign imm_ext = DATA_W'($signed(ir[15:0]));
    assign br_off  = PC_W'($signed(ir[15:0]));

    logic fn_ok;
    logic is_r;
    logic is_addi;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_j;
    logic legal;

    assign fn_ok = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};

    always_comb begin
        is_r    = 1'b0;
        is_addi = 1'b0;
        is_lw   = 1'b0;
        is_sw   = 1'b0;
        is_beq  = 1'b0;
        is_j    = 1'b0;
        unique case (1'b1)
            opcode == OP_RTYPE: is_r    = fn_ok;
            opcode == OP_ADDI:  is_addi = 1'b1;
            opcode == OP_LW:    is_lw   = 1'b1;
            opcode == OP_SW:    is_sw   = 1'b1;
            opcode == OP_BEQ:   is_beq  = 1'b1;
            opcode == OP_J:     is_j    = 1'b1;
            default: ;
        endcase
    end

    // OP_HALT and every unknown opcode/funct fall out as illegal.
    assign legal = is_r | is_addi | is_lw | is_sw | is_beq | is_j;

    alu_op_t           alu_op;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_res;
    logic              slt;

    always_comb begin
        alu_op = ALU_ADD;
        if (is_r) begin
            unique case (funct)
                FN_SUB:  alu_op = ALU_SUB;
                FN_AND:  alu_op = ALU_AND;
                FN_OR:   alu_op = ALU_OR;
                FN_SLT:  alu_op = ALU_SLT;
                default: alu_op = ALU_ADD;
            endcase
        end
    end

    assign alu_b = is_r ? b_q : imm_ext;
    assign slt   = $signed(a_q) < $signed(alu_b);

    always_comb begin
        alu_res = a_q + alu_b;
        case (alu_op)
            ALU_SUB: alu_res = a_q - alu_b;
            ALU_AND: alu_res = a_q & alu_b;
            ALU_OR:  alu_res = a_q | alu_b;
            ALU_SLT: alu_res = DATA_W'(slt);
            default: ;
        endcase
    end

    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              rf_we;
    logic [RW-1:0]     rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    assign rf_we    = (st == ST_WB);
    assign rf_waddr = is_r ? rd : rt;
    assign rf_wdata = is_lw ? mdr_q : alu_q;

    cpu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_rf (
        .clk    (MAX10_CLK1_50),
        .reset  (reset),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .we     (rf_we),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata)
    );

    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            st    <= ST_FETCH;
            pc_q  <= '0;
            ir    <= '0;
            a_q   <= '0;
            b_q   <= '0;
            alu_q <= '0;
            mdr_q <= '0;
        end else begin
            unique case (st)
                ST_FETCH: begin
                    if (imem_ready) begin
                        ir   <= imem_rdata;
                        pc_q <= pc_q + PC_W'(1);
                        st   <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    a_q <= rdata1;
                    b_q <= rdata2;
                    st  <= legal ? ST_EXEC : ST_HALT;
                end
                ST_EXEC: begin
                    alu_q <= alu_res;
                    if (is_beq) begin
                        // pc already points past the branch
                        if (a_q == b_q) begin
                            pc_q <= pc_q + br_off;
                        end
                        st <= ST_FETCH;
                    end else if (is_j) begin
                        pc_q <= ir[PC_W-1:0];
                        st   <= ST_FETCH;
                    end else if (is_lw || is_sw) begin
                        st <= ST_MEM;
                    end else begin
                        st <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (dmem_ready) begin
                        mdr_q <= dmem_rdata;
                        st    <= is_lw ? ST_WB : ST_FETCH;
                    end
                end
                ST_WB:   st <= ST_FETCH;
                ST_HALT: st <= ST_HALT;
                default: st <= ST_HALT;
            endcase
        end
    end

    // Requests are state decodes, masked while reset is held so an
    // aborted access drops immediately and fetch starts on release.
    assign imem_req   = (st == ST_FETCH) && !reset;
    assign imem_addr  = pc_q;
    assign dmem_req   = (st == ST_MEM) && !reset;
    assign dmem_we    = dmem_req && is_sw;
    assign dmem_addr  = alu_q[DADDR_W-1:0];
    assign dmem_wdata = b_q;
    assign pc         = pc_q;
    assign state      = st;
    assign halted     = (st == ST_HALT);

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Testbench for multi_cycle_cpu: directed scenarios plus random programs
// checked against an instruction-level reference model.
module tb_multi_cycle_cpu;
    import cpu_pkg::*;

    localparam int DATA_W  = 32;
    localparam int PC_W    = 8;
    localparam int DADDR_W = 10;
    localparam int NREGS   = 32;
    localparam logic [31:0] HALT_W = {OP_HALT, 26'd0};

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ready = 1'b0;
    logic [31:0]        imem_rdata;
    logic               dmem_req;
    logic               dmem_we;
    logic [DADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0]  dmem_wdata;
    logic               dmem_ready = 1'b0;
    logic [DATA_W-1:0]  dmem_rdata;
    logic [PC_W-1:0]    pc;
    logic [2:0]         state;
    logic               halted;

    always #5 clk = ~clk;

    multi_cycle_cpu #(
        .DATA_W  (DATA_W),
        .PC_W    (PC_W),
        .DADDR_W (DADDR_W),
        .NREGS   (NREGS)
    ) dut (
        .MAX10_CLK1_50 (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_ready    (dmem_ready),
        .dmem_rdata    (dmem_rdata),
        .pc            (pc),
        .state         (state),
        .halted        (halted)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] imem [256];
    logic [31:0] dmem [1024];
    logic [31:0] mdm  [1024];
    logic [31:0] mreg [32];

    assign imem_rdata = imem[imem_addr];
    assign dmem_rdata = dmem[dmem_addr];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // memory responders with programmable wait states
    int i_wmin = 0, i_wmax = 0, d_wmin = 0, d_wmax = 0;
    bit i_busy = 0, d_busy = 0;
    int i_left, d_left, d_cnt;
    int waits = 0;
    logic [PC_W-1:0]    i_addr0;
    logic [DADDR_W-1:0] d_addr0;
    logic [DATA_W-1:0]  d_wd0;
    logic               d_we0;
    logic [PC_W-1:0]    fetch_q [$];
    int                 dlen_q [$];

    always @(negedge clk) begin
        if (imem_req === 1'b1) begin
            if (!i_busy) begin
                i_busy  = 1;
                i_left  = int'($urandom_range(i_wmax, i_wmin));
                i_addr0 = imem_addr;
            end else begin
                chk("imem_addr_hold", 64'(imem_addr), 64'(i_addr0));
            end
            if (i_left == 0) begin
                imem_ready = 1'b1;
                i_busy = 0;
                fetch_q.push_back(imem_addr);
            end else begin
                imem_ready = 1'b0;
                i_left--;
                waits++;
            end
        end else begin
            imem_ready = 1'b0;
            i_busy = 0;
        end
    end

    always @(negedge clk) begin
        if (dmem_req === 1'b1) begin
            if (!d_busy) begin
                d_busy  = 1;
                d_left  = int'($urandom_range(d_wmax, d_wmin));
                d_cnt   = 0;
                d_addr0 = dmem_addr;
                d_wd0   = dmem_wdata;
                d_we0   = dmem_we;
            end else begin
                chk("dmem_addr_hold", 64'(dmem_addr), 64'(d_addr0));
                chk("dmem_wdata_hold", 64'(dmem_wdata), 64'(d_wd0));
                chk("dmem_we_hold", 64'(dmem_we), 64'(d_we0));
            end
            d_cnt++;
            if (d_left == 0) begin
                dmem_ready = 1'b1;
                d_busy = 0;
                dlen_q.push_back(d_cnt);
                if (dmem_we) dmem[dmem_addr] = dmem_wdata;
            end else begin
                dmem_ready = 1'b0;
                d_left--;
                waits++;
            end
        end else begin
            dmem_ready = 1'b0;
            d_busy = 0;
        end
    end

    function automatic logic [31:0] rtype(input logic [5:0] fn,
                                          input int rd, input int rs,
                                          input int rt);
        return {OP_RTYPE, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op,
                                          input int rt, input int rs,
                                          input int imm);
        return {op, rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic logic [31:0] jtype(input int tgt);
        return {OP_J, tgt[25:0]};
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = HALT_W;
    endtask

    task automatic set_waits(input int imn, input int imx,
                             input int dmn, input int dmx);
        i_wmin = imn; i_wmax = imx; d_wmin = dmn; d_wmax = dmx;
    endtask

    task automatic do_reset(input bit check);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        if (check) begin
            chk("rst_pc", 64'(pc), 64'(0));
            chk("rst_state", 64'(state), 64'(ST_FETCH));
            chk("rst_imem_req", 64'(imem_req), 64'(0));
            chk("rst_dmem_req", 64'(dmem_req), 64'(0));
            chk("rst_dmem_we", 64'(dmem_we), 64'(0));
            chk("rst_halted", 64'(halted), 64'(0));
            chk("rst_r7", 64'(dut.u_rf.regs[7]), 64'(0));
        end
        reset = 1'b0;
        waits = 0;
        fetch_q.delete();
        dlen_q.delete();
    endtask

    int cyc;
    bit done;

    // counts clock edges after reset release until halted is seen
    task automatic run_prog(input int budget);
        cyc = 0;
        done = 0;
        while (cyc < budget && !done) begin
            @(posedge clk); #1;
            cyc++;
            if (halted === 1'b1) done = 1;
        end
        chk("halt_reached", 64'(done), 64'(1));
    endtask

    // instruction-level reference: executes imem on mreg/mdm and
    // returns the zero-wait cycle count up to halted
    task automatic model_run(output int lat);
        int p, rs, rt, rd;
        logic [31:0] ir, a, b, imm, res, ea;
        logic [5:0] op, fn;
        bit stop;
        for (int i = 0; i < 32; i++) mreg[i] = '0;
        p = 0; lat = 0; stop = 0;
        for (int step = 0; step < 1000 && !stop; step++) begin
            ir  = imem[p];
            p   = (p + 1) % 256;
            op  = ir[31:26];
            fn  = ir[5:0];
            rs  = int'(ir[25:21]);
            rt  = int'(ir[20:16]);
            rd  = int'(ir[15:11]);
            a   = mreg[rs];
            b   = mreg[rt];
            imm = {{16{ir[15]}}, ir[15:0]};
            ea  = (a + imm) % 1024;
            if (op == 6'h00 && fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) begin
                case (fn)
                    6'h20:   res = a + b;
                    6'h22:   res = a - b;
                    6'h24:   res = a & b;
                    6'h25:   res = a | b;
                    default: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                endcase
                if (rd != 0) mreg[rd] = res;
                lat += 4;
            end else if (op == 6'h08) begin
                if (rt != 0) mreg[rt] = a + imm;
                lat += 4;
            end else if (op == 6'h23) begin
                if (rt != 0) mreg[rt] = mdm[ea[9:0]];
                lat += 5;
            end else if (op == 6'h2B) begin
                mdm[ea[9:0]] = b;
                lat += 4;
            end else if (op == 6'h04) begin
                if (a == b) p = (p + int'(imm)) & 255;
                lat += 3;
            end else if (op == 6'h02) begin
                p = int'(ir[7:0]);
                lat += 3;
            end else begin
                lat += 2;
                stop = 1;
            end
        end
    endtask

    int lat, bad, n, kind, cnt;
    logic [5:0] fns [5] = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};

    initial begin
        // zero-wait arithmetic program
        clear_imem();
        imem[0] = itype(OP_ADDI, 1, 0, 5);
        imem[1] = itype(OP_ADDI, 2, 0, -3);
        imem[2] = rtype(FN_ADD, 3, 1, 2);
        set_waits(0, 0, 0, 0);
        do_reset(1);
        #1;
        chk("first_imem_req", 64'(imem_req), 64'(1));
        chk("first_imem_addr", 64'(imem_addr), 64'(0));
        run_prog(200);
        chk("arith_cycles", 64'(cyc), 64'(14));
        chk("arith_r3", 64'(dut.u_rf.regs[3]), 64'(2));
        chk("arith_r2", 64'(dut.u_rf.regs[2]), 64'(32'hFFFF_FFFD));
        chk("arith_state", 64'(state), 64'(ST_HALT));

        // store then load with three wait states each
        clear_imem();
        imem[0] = itype(OP_ADDI, 1, 0, 5);
        imem[1] = itype(OP_SW, 1, 0, 7);
        imem[2] = itype(OP_LW, 4, 0, 7);
        dmem[7] = 32'h0;
        set_waits(0, 0, 3, 3);
        do_reset(0);
        run_prog(200);
        chk("mem_cycles", 64'(cyc), 64'(21));
        chk("mem_acc_count", 64'(dlen_q.size()), 64'(2));
        if (dlen_q.size() == 2) begin
            chk("sw_mem_len", 64'(dlen_q[0]), 64'(4));
            chk("lw_mem_len", 64'(dlen_q[1]), 64'(4));
        end
        chk("mem_dmem7", 64'(dmem[7]), 64'(5));
        chk("mem_r4", 64'(dut.u_rf.regs[4]), 64'(5));

        // taken beq loops on itself
        clear_imem();
        imem[0] = itype(OP_ADDI, 1, 0, 5);
        imem[1] = itype(OP_ADDI, 2, 0, 6);
        imem[2] = itype(OP_ADDI, 3, 0, 1);
        imem[3] = itype(OP_BEQ, 1, 1, -1);
        set_waits(0, 2, 0, 0);
        do_reset(0);
        repeat (60) @(posedge clk);
        #1;
        bad = 0;
        cnt = 0;
        foreach (fetch_q[i]) begin
            if (fetch_q[i] !== PC_W'((i < 3) ? i : 3)) bad++;
            if (i >= 3) cnt++;
        end
        chk("beq_loop_addrs", 64'(bad), 64'(0));
        chk("beq_loop_repeats", 64'(cnt >= 4), 64'(1));
        chk("beq_loop_running", 64'(halted), 64'(0));

        // untaken beq falls through
        imem[3] = itype(OP_BEQ, 2, 1, -1);
        do_reset(0);
        run_prog(300);
        chk("beq_nt_cycles", 64'(cyc), 64'(17 + waits));
        chk("beq_nt_fetches", 64'(fetch_q.size()), 64'(5));
        if (fetch_q.size() == 5) chk("beq_nt_last", 64'(fetch_q[4]), 64'(4));

        // jump to the last word, pc wraps on its fetch
        clear_imem();
        imem[0]   = jtype(255);
        imem[255] = itype(OP_ADDI, 1, 0, 7);
        set_waits(0, 0, 0, 0);
        do_reset(0);
        repeat (3) @(posedge clk);
        #1 chk("j_pc", 64'(pc), 64'(255));
        @(posedge clk);
        #1 chk("wrap_pc", 64'(pc), 64'(0));
        chk("wrap_state", 64'(state), 64'(ST_DECODE));
        repeat (3) @(posedge clk);
        #1 chk("wrap_r1", 64'(dut.u_rf.regs[1]), 64'(7));

        // reset during the second wait cycle of a load
        clear_imem();
        imem[0] = itype(OP_LW, 6, 0, 7);
        dmem[7] = 32'h1234;
        set_waits(0, 0, 3, 3);
        do_reset(0);
        cnt = 0;
        while (state !== ST_MEM && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("lw_reached_mem", 64'(state), 64'(ST_MEM));
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_state", 64'(state), 64'(ST_FETCH));
        chk("abort_pc", 64'(pc), 64'(0));
        chk("abort_dmem_req", 64'(dmem_req), 64'(0));
        chk("abort_r6", 64'(dut.u_rf.regs[6]), 64'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        run_prog(200);
        chk("rerun_r6", 64'(dut.u_rf.regs[6]), 64'(32'h1234));

        // writes to r0 discarded, illegal opcode halts
        clear_imem();
        imem[0] = itype(OP_ADDI, 5, 0, 77);
        imem[1] = itype(OP_ADDI, 0, 0, 9);
        imem[2] = rtype(FN_ADD, 5, 0, 0);
        imem[3] = {6'h11, 26'd0};
        set_waits(0, 0, 0, 0);
        do_reset(0);
        run_prog(200);
        chk("ill_cycles", 64'(cyc), 64'(14));
        chk("r0_zero", 64'(dut.u_rf.regs[0]), 64'(0));
        chk("r5_zero", 64'(dut.u_rf.regs[5]), 64'(0));
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (imem_req !== 1'b0 || dmem_req !== 1'b0) cnt++;
        end
        chk("halt_no_req", 64'(cnt), 64'(0));
        chk("halt_hold", 64'(halted), 64'(1));

        // random programs with random wait states
        for (int run = 0; run < 6; run++) begin
            clear_imem();
            n = 0;
            for (int k = 0; k < 14; k++) begin
                kind = int'($urandom_range(5, 0));
                case (kind)
                    0: imem[n] = itype(OP_ADDI, int'($urandom_range(7, 0)),
                                       int'($urandom_range(7, 0)), int'($urandom));
                    1, 5: imem[n] = rtype(fns[$urandom_range(4, 0)],
                                          int'($urandom_range(7, 0)),
                                          int'($urandom_range(7, 0)),
                                          int'($urandom_range(7, 0)));
                    2: imem[n] = itype(OP_LW, int'($urandom_range(7, 0)),
                                       int'($urandom_range(7, 0)), int'($urandom));
                    3: imem[n] = itype(OP_SW, int'($urandom_range(7, 0)),
                                       int'($urandom_range(7, 0)), int'($urandom));
                    default: imem[n] = itype(OP_BEQ, int'($urandom_range(7, 0)),
                                             int'($urandom_range(7, 0)), 1);
                endcase
                n++;
            end
            for (int r = 1; r < 8; r++) begin
                imem[n] = itype(OP_SW, r, 0, 200 + r);
                n++;
            end
            for (int i = 0; i < 1024; i++) begin
                dmem[i] = $urandom;
                mdm[i]  = dmem[i];
            end
            model_run(lat);
            set_waits(0, 2, 0, 2);
            do_reset(0);
            run_prog(2000);
            chk($sformatf("rand%0d_cycles", run), 64'(cyc), 64'(lat + waits));
            bad = 0;
            for (int i = 0; i < 1024; i++) if (dmem[i] !== mdm[i]) bad++;
            chk($sformatf("rand%0d_dmem", run), 64'(bad), 64'(0));
            for (int r = 1; r < 8; r++) begin
                chk($sformatf("rand%0d_r%0d", run, r),
                    64'(dut.u_rf.regs[r]), 64'(mreg[r]));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
